urna_terminal: RTL and testbench
================================

URNA_TERMINAL -- requirements
Module: urna_terminal

Interface
REQ-001 Parameter TIMEOUT, default 200: idle cycles allowed per voter session, range 2..255.
REQ-002 Parameter PULSO, default 2: width in cycles of every valid and finish pulse, range 1..15.
REQ-003 clock  input  1  single clock; all logic rises on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tecla  input  4  key code presented with tecla_ok.
REQ-006 tecla_ok  input  1  one-cycle key-press strobe.
REQ-007 confirma  input  1  one-cycle confirm strobe.
REQ-008 corrige  input  1  one-cycle correct/erase strobe.
REQ-009 libera  input  1  one-cycle poll-worker strobe that admits the next voter.
REQ-010 encerra  input  1  one-cycle poll-worker strobe that closes the poll.
REQ-011 swap_cfg  input  1  candidate-swap configuration.
REQ-012 voto  output  4  captured vote code sent to the counting unit.
REQ-013 swap  output  1  registered copy of swap_cfg.
REQ-014 valid  output  1  vote-commit pulse, PULSO cycles high.
REQ-015 finish  output  1  close-poll pulse, PULSO cycles high.
REQ-016 estado  output  3  current FSM state code.
REQ-017 eleitores  output  8  count of committed votes.
REQ-018 abstencoes  output  8  count of timed-out sessions.

Function
REQ-019 States SHALL be BLOQUEADO=0, DIGITANDO=1, CONFIRMANDO=2, ENVIANDO=3, ENCERRADO=4; codes 5..7 SHALL go to BLOQUEADO on the next cycle.
REQ-020 All outputs SHALL be registered.
REQ-021 The codes at the counting unit are 1010 for candidate 1 and 1111 for candidate 2; every other code is null. voto SHALL pass tecla unmodified; no code SHALL be rejected.
REQ-022 BLOQUEADO: encerra -> ENCERRADO; otherwise libera -> DIGITANDO with timer=0. encerra SHALL win over libera.
REQ-023 BLOQUEADO: swap SHALL load swap_cfg every cycle. In all other states swap SHALL hold its value.
REQ-024 DIGITANDO: tecla_ok SHALL load voto<=tecla and move to CONFIRMANDO with timer=0. confirma and corrige SHALL be ignored.
REQ-025 CONFIRMANDO: confirma -> ENVIANDO. corrige -> DIGITANDO with voto<=0 and timer=0. corrige SHALL win when both are strobed in the same cycle. tecla_ok SHALL NOT overwrite voto.
REQ-026 DIGITANDO/CONFIRMANDO: the 8-bit timer SHALL increment each cycle without a strobe.
REQ-027 Timeout: when the timer equals TIMEOUT-1 and no strobe is present, the FSM SHALL go to BLOQUEADO, increment abstencoes and not assert valid. A strobe on that same cycle SHALL take priority over the timeout.
REQ-028 encerra and libera SHALL be ignored in DIGITANDO, CONFIRMANDO and ENVIANDO.
REQ-029 ENVIANDO: valid SHALL be high for exactly PULSO cycles, starting the cycle after confirma is sampled, with voto stable throughout.
REQ-030 On the cycle valid falls, eleitores SHALL increment and the FSM SHALL enter BLOQUEADO.
REQ-031 voto SHALL hold its value until the next capture or corrige.
REQ-032 On entry to ENCERRADO, finish SHALL pulse high for PULSO cycles.
REQ-033 Each later encerra in ENCERRADO, sampled while finish is low, SHALL start another PULSO-cycle finish pulse (the counting unit needs two finish pulses to publish totals).
REQ-034 encerra while finish is high SHALL be ignored. libera in ENCERRADO SHALL be ignored. Only reset SHALL leave ENCERRADO.
REQ-035 eleitores and abstencoes SHALL saturate at 255.
REQ-036 valid and finish SHALL never be high in the same cycle.

Reset
REQ-037 reset SHALL be sampled only at posedge clock and SHALL override every other input.
REQ-038 On reset: estado=BLOQUEADO, voto=0000, swap=0, valid=0, finish=0, eleitores=0, abstencoes=0, timer=0, pulse counter=0.
REQ-039 reset during ENVIANDO SHALL drop valid on the next edge and SHALL NOT increment eleitores.

Verification
REQ-040 Normal vote: reset; libera; tecla=1010 with tecla_ok; confirma -> valid high for 2 cycles with voto=1010; eleitores=1; estado=0.
REQ-041 Correction: libera; tecla 1111; corrige; tecla 1010; confirma -> voto=0000 after corrige; valid pulse carries 1010; eleitores=+1.
REQ-042 Timeout: TIMEOUT=5; libera; no strobes -> return to estado=0 after 5 cycles in DIGITANDO; abstencoes=1; valid never high.
REQ-043 Simultaneous strobes: in CONFIRMANDO assert confirma+corrige together -> DIGITANDO, no valid; in BLOQUEADO assert libera+encerra together -> ENCERRADO, finish pulses 2 cycles.
REQ-044 Close twice: in ENCERRADO strobe encerra again after the first pulse -> second 2-cycle finish pulse; encerra during a pulse gives no extra pulse; libera ignored.
REQ-045 Reset and saturation: reset mid-ENVIANDO -> all outputs per REQ-038 next cycle; after 256 commits eleitores=255.

Source files
------------

// File: rtl/urna_terminal.sv
// rtl/urna_terminal.sv - voting terminal controller: key capture, confirm, timeout and close-poll pulses
module urna_terminal #(
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned PULSO   = 2
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [3:0] tecla_i,
    input  logic       tecla_ok_i,
    input  logic       confirma_i,
    input  logic       corrige_i,
    input  logic       libera_i,
    input  logic       encerra_i,
    input  logic       swap_cfg_i,
    output logic [3:0] voto_o,
    output logic       swap_o,
    output logic       valid_o,
    output logic       finish_o,
    output logic [2:0] estado_o,
    output logic [7:0] eleitores_o,
    output logic [7:0] abstencoes_o
);

    typedef enum logic [2:0] {
        BLOQUEADO   = 3'd0,
        DIGITANDO   = 3'd1,
        CONFIRMANDO = 3'd2,
        ENVIANDO    = 3'd3,
        ENCERRADO   = 3'd4
    } estado_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] PULSE_LAST = 4'(PULSO - 1);

    estado_t    estado_q;
    logic [3:0] voto_q;
    logic       swap_q;
    logic       valid_q;
    logic       finish_q;
    logic [7:0] eleitores_q;
    logic [7:0] abstencoes_q;
    logic [7:0] timer_q;
    logic [3:0] pulse_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            estado_q     <= BLOQUEADO;
            voto_q       <= 4'd0;
            swap_q       <= 1'b0;
            valid_q      <= 1'b0;
            finish_q     <= 1'b0;
            eleitores_q  <= 8'd0;
            abstencoes_q <= 8'd0;
            timer_q      <= 8'd0;
            pulse_q      <= 4'd0;
        end else begin
            case (estado_q)
                BLOQUEADO: begin
                    swap_q   <= swap_cfg_i;
                    valid_q  <= 1'b0;
                    finish_q <= 1'b0;
                    if (encerra_i) begin
                        estado_q <= ENCERRADO;
                        finish_q <= 1'b1;
                        pulse_q  <= 4'd0;
                    end else if (libera_i) begin
                        estado_q <= DIGITANDO;
                        timer_q  <= 8'd0;
                    end
                end
                DIGITANDO: begin
                    // A key press on the last allowed cycle still counts as activity.
                    if (tecla_ok_i) begin
                        voto_q   <= tecla_i;
                        estado_q <= CONFIRMANDO;
                        timer_q  <= 8'd0;
                    end else if (timer_q == TIMER_LAST) begin
                        estado_q <= BLOQUEADO;
                        if (abstencoes_q != 8'hFF) abstencoes_q <= abstencoes_q + 8'd1;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                CONFIRMANDO: begin
                    if (corrige_i) begin
                        voto_q   <= 4'd0;
                        estado_q <= DIGITANDO;
                        timer_q  <= 8'd0;
                    end else if (confirma_i) begin
                        estado_q <= ENVIANDO;
                        valid_q  <= 1'b1;
                        pulse_q  <= 4'd0;
                    end else if (timer_q == TIMER_LAST) begin
                        estado_q <= BLOQUEADO;
                        if (abstencoes_q != 8'hFF) abstencoes_q <= abstencoes_q + 8'd1;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                ENVIANDO: begin
                    // The vote is counted only when the pulse completes, so a reset mid-pulse drops it.
                    if (pulse_q == PULSE_LAST) begin
                        valid_q  <= 1'b0;
                        estado_q <= BLOQUEADO;
                        if (eleitores_q != 8'hFF) eleitores_q <= eleitores_q + 8'd1;
                    end else begin
                        pulse_q <= pulse_q + 4'd1;
                    end
                end
                ENCERRADO: begin
                    valid_q <= 1'b0;
                    if (finish_q) begin
                        if (pulse_q == PULSE_LAST) finish_q <= 1'b0;
                        else                       pulse_q  <= pulse_q + 4'd1;
                    end else if (encerra_i) begin
                        finish_q <= 1'b1;
                        pulse_q  <= 4'd0;
                    end
                end
                default: begin
                    estado_q <= BLOQUEADO;
                    valid_q  <= 1'b0;
                    finish_q <= 1'b0;
                end
            endcase
        end
    end

    assign voto_o       = voto_q;
    assign swap_o       = swap_q;
    assign valid_o      = valid_q;
    assign finish_o     = finish_q;
    assign estado_o     = estado_q;
    assign eleitores_o  = eleitores_q;
    assign abstencoes_o = abstencoes_q;

endmodule

// File: tb/tb_urna_terminal.sv
// tb/tb_urna_terminal.sv - directed checks of the voting terminal with TIMEOUT=5, PULSO=2
module tb_urna_terminal;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] tecla = 4'd0;
    logic       tecla_ok = 1'b0;
    logic       confirma = 1'b0;
    logic       corrige = 1'b0;
    logic       libera = 1'b0;
    logic       encerra = 1'b0;
    logic       swap_cfg = 1'b0;
    logic [3:0] voto;
    logic       swap;
    logic       valid;
    logic       finish;
    logic [2:0] estado;
    logic [7:0] eleitores;
    logic [7:0] abstencoes;

    int n_cmp = 0;
    int n_err = 0;

    urna_terminal #(.TIMEOUT(5), .PULSO(2)) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .tecla_i      (tecla),
        .tecla_ok_i   (tecla_ok),
        .confirma_i   (confirma),
        .corrige_i    (corrige),
        .libera_i     (libera),
        .encerra_i    (encerra),
        .swap_cfg_i   (swap_cfg),
        .voto_o       (voto),
        .swap_o       (swap),
        .valid_o      (valid),
        .finish_o     (finish),
        .estado_o     (estado),
        .eleitores_o  (eleitores),
        .abstencoes_o (abstencoes)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_libera();
        libera = 1'b1; tick(); libera = 1'b0;
    endtask

    task automatic do_tecla(input logic [3:0] k);
        tecla = k; tecla_ok = 1'b1; tick(); tecla_ok = 1'b0;
    endtask

    task automatic do_confirma();
        confirma = 1'b1; tick(); confirma = 1'b0;
    endtask

    initial begin
        // reset state
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        chk("rst_estado", estado, 0);
        chk("rst_voto", voto, 0);
        chk("rst_swap", swap, 0);
        chk("rst_valid", valid, 0);
        chk("rst_finish", finish, 0);
        chk("rst_eleitores", eleitores, 0);
        chk("rst_abstencoes", abstencoes, 0);

        // swap loads in BLOQUEADO, holds elsewhere
        swap_cfg = 1'b1; tick();
        chk("swap_load", swap, 1);

        // normal vote
        do_libera();
        chk("nv_estado_dig", estado, 1);
        swap_cfg = 1'b0;
        do_tecla(4'b1010);
        chk("swap_hold", swap, 1);
        chk("nv_estado_conf", estado, 2);
        chk("nv_voto", voto, 4'b1010);
        do_confirma();
        chk("nv_estado_env", estado, 3);
        chk("nv_valid1", valid, 1);
        chk("nv_voto_env", voto, 4'b1010);
        tick();
        chk("nv_valid2", valid, 1);
        chk("nv_eleit_mid", eleitores, 0);
        tick();
        chk("nv_valid_fall", valid, 0);
        chk("nv_eleitores", eleitores, 1);
        chk("nv_estado_end", estado, 0);
        chk("nv_voto_hold", voto, 4'b1010);

        // correction
        do_libera();
        do_tecla(4'b1111);
        chk("cor_voto_f", voto, 4'b1111);
        corrige = 1'b1; tick(); corrige = 1'b0;
        chk("cor_voto_zero", voto, 0);
        chk("cor_estado", estado, 1);
        do_tecla(4'b1010);
        do_confirma();
        chk("cor_valid", valid, 1);
        chk("cor_voto", voto, 4'b1010);
        tick(); tick();
        chk("cor_eleitores", eleitores, 2);
        chk("cor_estado_end", estado, 0);

        // timeout in DIGITANDO: five cycles in the state
        do_libera();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_valid_low", valid, 0);
        end
        chk("to_still_dig", estado, 1);
        tick();
        chk("to_estado", estado, 0);
        chk("to_abstencoes", abstencoes, 1);
        chk("to_valid_end", valid, 0);

        // key on the last cycle beats the timeout, then CONFIRMANDO times out
        do_libera();
        for (int i = 0; i < 4; i++) tick();
        do_tecla(4'b1001);
        chk("to_edge_estado", estado, 2);
        chk("to_edge_abst", abstencoes, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("to_conf_still", estado, 2);
        tick();
        chk("to_conf_estado", estado, 0);
        chk("to_conf_abst", abstencoes, 2);
        chk("to_conf_voto", voto, 4'b1001);

        // confirma + corrige together: corrige wins
        do_libera();
        do_tecla(4'b0101);
        confirma = 1'b1; corrige = 1'b1; tick(); confirma = 1'b0; corrige = 1'b0;
        chk("both_estado", estado, 1);
        chk("both_voto", voto, 0);
        chk("both_valid", valid, 0);
        encerra = 1'b1; tick(); encerra = 1'b0;
        chk("enc_ign_estado", estado, 1);
        chk("enc_ign_finish", finish, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("both_to_estado", estado, 0);
        chk("both_to_abst", abstencoes, 3);

        // libera + encerra together: close wins
        libera = 1'b1; encerra = 1'b1; tick(); libera = 1'b0;
        chk("close_estado", estado, 4);
        chk("close_fin1", finish, 1);
        tick(); encerra = 1'b0;
        chk("close_fin2", finish, 1);
        chk("close_valid", valid, 0);
        tick();
        chk("close_fin_fall", finish, 0);
        tick();
        chk("close_no_extra", finish, 0);
        do_libera();
        chk("close_lib_estado", estado, 4);
        chk("close_lib_finish", finish, 0);
        encerra = 1'b1; tick(); encerra = 1'b0;
        chk("close2_fin1", finish, 1);
        tick();
        chk("close2_fin2", finish, 1);
        tick();
        chk("close2_fall", finish, 0);
        chk("close2_estado", estado, 4);

        // reset mid-ENVIANDO
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst2_estado", estado, 0);
        do_libera();
        do_tecla(4'b1010);
        do_confirma();
        chk("rme_valid_pre", valid, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rme_valid", valid, 0);
        chk("rme_estado", estado, 0);
        chk("rme_voto", voto, 0);
        chk("rme_eleitores", eleitores, 0);
        chk("rme_abst", abstencoes, 0);
        chk("rme_finish", finish, 0);
        chk("rme_swap", swap, 0);
        tick();
        chk("rme_eleit_after", eleitores, 0);

        // saturation of eleitores
        for (int n = 1; n <= 256; n++) begin
            do_libera();
            do_tecla(4'b1111);
            do_confirma();
            tick(); tick();
            if (n == 1)   chk("sat_1", eleitores, 1);
            if (n == 255) chk("sat_255", eleitores, 255);
        end
        chk("sat_256", eleitores, 255);
        chk("sat_estado", estado, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
